// File: rtl/arcade_spinner_pkg.sv
// Shared types and helpers for the arcade_spinner rotary-control accumulator.
package arcade_spinner_pkg;

  // Direction of the last nonzero movement (and of a digital hold run).
  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } spin_dir_e;

  // Low bit of channel idx inside a packed bus of w-bit fields.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

  // Add two sign-extended operands and fit the result into w bits:
  // clamp to the signed limits when sat is set, otherwise pass the sum
  // through so the caller's truncation wraps it modulo 2^w.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int                 w,
                                                 input logic               sat);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = a + b;
    hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (w - 1));
    if (sat && (sum > hi)) return hi;
    if (sat && (sum < lo)) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/arcade_spinner_if.sv
// Bus bundle between the input-mapping logic (master) and arcade_spinner (slave).
interface arcade_spinner_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 9,
  parameter int DELTA_W  = 9
);
  // Flow control: delta_strobe is a valid-only, one-cycle-per-packet strobe with
  // no ready; the slave consumes every strobed delta on the edge that samples it.
  // All other inputs are level-sampled every cycle.
  logic [CHANNELS-1:0]         delta_strobe;
  logic [CHANNELS*DELTA_W-1:0] delta;
  logic [CHANNELS-1:0]         dig_left;
  logic [CHANNELS-1:0]         dig_right;
  logic [CHANNELS-1:0]         center;
  logic [CHANNELS*WIDTH-1:0]   spin;
  logic [CHANNELS-1:0]         moved;
  logic [CHANNELS-1:0]         dir;

  modport master (
    output delta_strobe, delta, dig_left, dig_right, center,
    input  spin, moved, dir
  );

  modport slave (
    input  delta_strobe, delta, dig_left, dig_right, center,
    output spin, moved, dir
  );
endinterface

// File: rtl/arcade_spinner_channel.sv
// One dial: accumulator, change pulse, direction and digital step generation.
// Acceleration of the digital step is built only when SPINNER_ACCEL_EN is defined.
module arcade_spinner_channel
  import arcade_spinner_pkg::*;
#(
  parameter int WIDTH       = 9,
  parameter int DELTA_W     = 9,
  parameter int SATURATE    = 1,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 8,
  parameter int ACCEL_TICKS = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tick_i,
  input  logic               strobe_i,
  input  logic [DELTA_W-1:0] delta_i,
  input  logic               left_i,
  input  logic               right_i,
  input  logic               center_i,
  output logic [WIDTH-1:0]   spin_o,
  output logic               moved_o,
  output logic               dir_o
);
  localparam int SUM_W  = WIDTH + 2;
  localparam int STEP_W = $clog2(STEP_MAX + 1);

  if (ACCEL_TICKS < 1) begin : g_chk_accel
    $error("ACCEL_TICKS must be at least 1");
  end

  logic                    one_held;
  logic                    hold_neg;
  logic [STEP_W-1:0]       eff_step;
  logic signed [SUM_W-1:0] delta_term;
  logic signed [SUM_W-1:0] step_mag;
  logic signed [SUM_W-1:0] step_term;
  logic signed [SUM_W-1:0] term;
  logic [WIDTH-1:0]        spin_q, spin_d;
  logic                    moved_q, moved_d;
  spin_dir_e               dir_q, dir_d;

  // Exactly one of left/right held gives a digital step; both or neither do not.
  assign one_held = left_i ^ right_i;
  assign hold_neg = left_i;

`ifdef SPINNER_ACCEL_EN
  localparam int HCNT_W = $clog2(ACCEL_TICKS + 1);

  logic [STEP_W-1:0] step_q, step_d, base_step;
  logic [HCNT_W-1:0] hold_cnt_q, hold_cnt_d, base_cnt;
  spin_dir_e         hold_dir_q, hold_dir_d;
  logic              same_run;

  // A run survives only while the same single direction stays held; a new
  // run starts at STEP_MIN, so a reversal tick already uses the base step.
  always_comb begin
    same_run   = one_held && (hold_dir_q == spin_dir_e'(hold_neg));
    base_step  = same_run ? step_q : STEP_W'(STEP_MIN);
    base_cnt   = same_run ? hold_cnt_q : '0;
    step_d     = base_step;
    hold_cnt_d = base_cnt;
    hold_dir_d = one_held ? spin_dir_e'(hold_neg) : hold_dir_q;
    if (one_held && tick_i) begin
      if (32'(base_cnt) + 1 >= ACCEL_TICKS) begin
        hold_cnt_d = '0;
        if (32'(base_step) < STEP_MAX) step_d = base_step + 1'b1;
      end else begin
        hold_cnt_d = base_cnt + 1'b1;
      end
    end
  end

  // Acceleration state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step_q     <= STEP_W'(STEP_MIN);
      hold_cnt_q <= '0;
      hold_dir_q <= DIR_POS;
    end else begin
      step_q     <= step_d;
      hold_cnt_q <= hold_cnt_d;
      hold_dir_q <= hold_dir_d;
    end
  end

  assign eff_step = base_step;
`else
  assign eff_step = STEP_W'(STEP_MIN);
`endif

  assign delta_term = strobe_i ? SUM_W'(signed'(delta_i)) : '0;
  assign step_mag   = SUM_W'(eff_step);
  assign step_term  = (tick_i && one_held) ? (hold_neg ? -step_mag : step_mag) : '0;
  assign term       = delta_term + step_term;

  // Next position, change pulse and direction; center overrides the update.
  always_comb begin
    spin_d  = WIDTH'(sat_add(32'(signed'(spin_q)), 32'(term), WIDTH, SATURATE != 0));
    moved_d = (spin_d != spin_q);
    dir_d   = dir_q;
    if (term != '0) dir_d = term[SUM_W-1] ? DIR_NEG : DIR_POS;
    if (center_i) begin
      spin_d  = '0;
      moved_d = (spin_q != '0);
      dir_d   = dir_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spin_q  <= '0;
      moved_q <= 1'b0;
      dir_q   <= DIR_POS;
    end else begin
      spin_q  <= spin_d;
      moved_q <= moved_d;
      dir_q   <= dir_d;
    end
  end

  assign spin_o  = spin_q;
  assign moved_o = moved_q;
  assign dir_o   = dir_q;

endmodule

// File: rtl/arcade_spinner.sv
// Multi-channel rotary-control accumulator: shared digital-step tick counter
// plus one arcade_spinner_channel per dial. Define SPINNER_ACCEL_EN to enable
// acceleration of the digital step.
module arcade_spinner
  import arcade_spinner_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 9,
  parameter int DELTA_W     = 9,
  parameter int SATURATE    = 1,
  parameter int DIV         = 40000,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 8,
  parameter int ACCEL_TICKS = 8
) (
  input  logic            clk_sys,
  input  logic            reset,
  arcade_spinner_if.slave bus
);
  localparam int CNT_W = $clog2(DIV);

  // The WIDTH+2 intermediate cannot overflow only while these hold.
  if (DELTA_W > WIDTH + 1) begin : g_chk_delta_w
    $error("DELTA_W must not exceed WIDTH+1");
  end
  if (WIDTH + 2 > 32 || WIDTH < 2) begin : g_chk_width
    $error("WIDTH must lie in 2..30");
  end
  if (DIV < 2) begin : g_chk_div
    $error("DIV must be at least 2");
  end
  if (STEP_MIN < 1 || STEP_MAX < STEP_MIN || STEP_MAX >= (1 << (WIDTH - 1))) begin : g_chk_step
    $error("need 1 <= STEP_MIN <= STEP_MAX < 2^(WIDTH-1)");
  end

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  assign tick = (tick_cnt_q == CNT_W'(DIV - 1));

  // Free-running 0..DIV-1 phase shared by every channel.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Tick phase register.
  always_ff @(posedge clk_sys) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    arcade_spinner_channel #(
      .WIDTH       (WIDTH),
      .DELTA_W     (DELTA_W),
      .SATURATE    (SATURATE),
      .STEP_MIN    (STEP_MIN),
      .STEP_MAX    (STEP_MAX),
      .ACCEL_TICKS (ACCEL_TICKS)
    ) u_ch (
      .clk_i    (clk_sys),
      .rst_i    (reset),
      .tick_i   (tick),
      .strobe_i (bus.delta_strobe[i]),
      .delta_i  (bus.delta[slice_lo(i, DELTA_W) +: DELTA_W]),
      .left_i   (bus.dig_left[i]),
      .right_i  (bus.dig_right[i]),
      .center_i (bus.center[i]),
      .spin_o   (bus.spin[slice_lo(i, WIDTH) +: WIDTH]),
      .moved_o  (bus.moved[i]),
      .dir_o    (bus.dir[i])
    );
  end

endmodule

// File: tb/tb_arcade_spinner.sv
// Bench for arcade_spinner: a saturating and a wrapping instance share stimulus.
module tb_arcade_spinner;
  localparam int CH    = 2;
  localparam int W     = 9;
  localparam int DW    = 9;
  localparam int DIV_T = 4;
  localparam int SMIN  = 1;
  localparam int SMAX  = 8;
  localparam int ACC   = 8;
  localparam int OUT_W = CH * W + 2 * CH;
`ifdef SPINNER_ACCEL_EN
  localparam int EXP_HOLD = 12;
`else
  localparam int EXP_HOLD = 10;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [CH-1:0]    strobe, left, right, center;
  logic [CH*DW-1:0] delta;

  arcade_spinner_if #(.CHANNELS(CH), .WIDTH(W), .DELTA_W(DW)) bus_sat ();
  arcade_spinner_if #(.CHANNELS(CH), .WIDTH(W), .DELTA_W(DW)) bus_wrap ();

  assign bus_sat.delta_strobe  = strobe;
  assign bus_sat.delta         = delta;
  assign bus_sat.dig_left      = left;
  assign bus_sat.dig_right     = right;
  assign bus_sat.center        = center;
  assign bus_wrap.delta_strobe = strobe;
  assign bus_wrap.delta        = delta;
  assign bus_wrap.dig_left     = left;
  assign bus_wrap.dig_right    = right;
  assign bus_wrap.center       = center;

  arcade_spinner #(.CHANNELS(CH), .WIDTH(W), .DELTA_W(DW), .SATURATE(1), .DIV(DIV_T),
                   .STEP_MIN(SMIN), .STEP_MAX(SMAX), .ACCEL_TICKS(ACC))
    dut_sat (.clk_sys(clk), .reset(rst), .bus(bus_sat));

  arcade_spinner #(.CHANNELS(CH), .WIDTH(W), .DELTA_W(DW), .SATURATE(0), .DIV(DIV_T),
                   .STEP_MIN(SMIN), .STEP_MAX(SMAX), .ACCEL_TICKS(ACC))
    dut_wrap (.clk_sys(clk), .reset(rst), .bus(bus_wrap));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [OUT_W-1:0] exp_sat_q[$];
  logic [OUT_W-1:0] exp_wrap_q[$];

  task automatic check_vec(input string name, input logic [OUT_W-1:0] act,
                           input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Positions are plain integers; the digital step is derived from how many
  // ticks the current single-direction run has lasted.
  int m_pos   [2][CH];
  bit m_moved [2][CH];
  bit m_dir   [2][CH];
  int m_run_len [CH];
  bit m_run_neg [CH];
  int m_phase = 0;

  function automatic int clamp_w(input int v);
    int hi, lo;
    hi = (1 << (W - 1)) - 1;
    lo = -(1 << (W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int wrap_w(input int v);
    int m, r;
    m = 1 << W;
    r = (v + m / 2) % m;
    if (r < 0) r += m;
    return r - m / 2;
  endfunction

  task automatic model_step();
    bit tick, one;
    int st, dterm, sterm, term, old, nv;
    logic [CH*W-1:0] sp [2];
    logic [CH-1:0]   mv [2];
    logic [CH-1:0]   dr [2];
    tick = (m_phase == DIV_T - 1);
    for (int c = 0; c < CH; c++) begin
      one = left[c] ^ right[c];
      if (!one) m_run_len[c] = 0;
      else begin
        if (left[c] != m_run_neg[c]) m_run_len[c] = 0;
        m_run_neg[c] = left[c];
      end
      st = SMIN;
`ifdef SPINNER_ACCEL_EN
      st = SMIN + m_run_len[c] / ACC;
      if (st > SMAX) st = SMAX;
`endif
      sterm = 0;
      if (tick && one) begin
        sterm = left[c] ? -st : st;
        m_run_len[c]++;
      end
      dterm = strobe[c] ? int'($signed(delta[c*DW +: DW])) : 0;
      term  = dterm + sterm;
      for (int s = 0; s < 2; s++) begin
        old = m_pos[s][c];
        if (rst) begin
          nv = 0;
          m_moved[s][c] = 1'b0;
          m_dir[s][c]   = 1'b0;
        end else if (center[c]) begin
          nv = 0;
          m_moved[s][c] = (old != 0);
        end else begin
          nv = (s == 0) ? clamp_w(old + term) : wrap_w(old + term);
          m_moved[s][c] = (nv != old);
          if (term != 0) m_dir[s][c] = (term < 0);
        end
        m_pos[s][c]     = nv;
        sp[s][c*W +: W] = nv[W-1:0];
        mv[s][c]        = m_moved[s][c];
        dr[s][c]        = m_dir[s][c];
      end
      if (rst) m_run_len[c] = 0;
    end
    m_phase = (rst || tick) ? 0 : m_phase + 1;
    exp_sat_q.push_back({sp[0], mv[0], dr[0]});
    exp_wrap_q.push_back({sp[1], mv[1], dr[1]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    strobe = '0;
    left   = '0;
    right  = '0;
    center = '0;
    delta  = '0;
  endtask

  // One clock: predict, advance, then compare both instances against the model.
  task automatic run_cycle();
    model_step();
    @(posedge clk);
    #1;
    check_vec("model_sat", {bus_sat.spin, bus_sat.moved, bus_sat.dir}, exp_sat_q.pop_front());
    check_vec("model_wrap", {bus_wrap.spin, bus_wrap.moved, bus_wrap.dir}, exp_wrap_q.pop_front());
  endtask

  function automatic int spin0_sat();
    return int'($signed(bus_sat.spin[W-1:0]));
  endfunction

  function automatic int spin0_wrap();
    return int'($signed(bus_wrap.spin[W-1:0]));
  endfunction

  typedef struct {
    bit stb;
    int dlt;
    bit ctr;
    int s_sat;
    bit m_sat;
    bit d_sat;
    int s_wrap;
    bit m_wrap;
    bit d_wrap;
  } vec_t;

  vec_t vecs[14];

  // ---------------- stimulus ----------------
  initial begin
    vecs[0]  = '{1,  250, 0,  250, 1, 0,  250, 1, 0};
    vecs[1]  = '{1,   10, 0,  255, 1, 0, -252, 1, 0};
    vecs[2]  = '{1,    1, 0,  255, 0, 0, -251, 1, 0};
    vecs[3]  = '{0,    0, 0,  255, 0, 0, -251, 0, 0};
    vecs[4]  = '{0,    0, 1,    0, 1, 0,    0, 1, 0};
    vecs[5]  = '{1, -256, 0, -256, 1, 1, -256, 1, 1};
    vecs[6]  = '{1,   -1, 0, -256, 0, 1,  255, 1, 1};
    vecs[7]  = '{1,    1, 0, -255, 1, 0, -256, 1, 0};
    vecs[8]  = '{1,    0, 0, -255, 0, 0, -256, 0, 0};
    vecs[9]  = '{0,    0, 1,    0, 1, 0,    0, 1, 0};
    vecs[10] = '{1,   50, 0,   50, 1, 0,   50, 1, 0};
    vecs[11] = '{1,  -10, 0,   40, 1, 1,   40, 1, 1};
    vecs[12] = '{1,    3, 1,    0, 1, 1,    0, 1, 1};
    vecs[13] = '{0,    0, 1,    0, 0, 1,    0, 0, 1};

    clear_inputs();
    rst = 1'b1;
    repeat (3) run_cycle();
    check_vec("reset_sat", {bus_sat.spin, bus_sat.moved, bus_sat.dir}, '0);
    check_vec("reset_wrap", {bus_wrap.spin, bus_wrap.moved, bus_wrap.dir}, '0);
    rst = 1'b0;

    // Table: single-cycle deltas and centers on channel 0.
    for (int i = 0; i < 14; i++) begin
      clear_inputs();
      strobe[0]     = vecs[i].stb;
      delta[DW-1:0] = DW'(vecs[i].dlt);
      center[0]     = vecs[i].ctr;
      run_cycle();
      check_int($sformatf("t%0d_spin_sat", i), spin0_sat(), vecs[i].s_sat);
      check_int($sformatf("t%0d_moved_sat", i), int'(bus_sat.moved[0]), int'(vecs[i].m_sat));
      check_int($sformatf("t%0d_dir_sat", i), int'(bus_sat.dir[0]), int'(vecs[i].d_sat));
      check_int($sformatf("t%0d_spin_wrap", i), spin0_wrap(), vecs[i].s_wrap);
      check_int($sformatf("t%0d_moved_wrap", i), int'(bus_wrap.moved[0]), int'(vecs[i].m_wrap));
      check_int($sformatf("t%0d_dir_wrap", i), int'(bus_wrap.dir[0]), int'(vecs[i].d_wrap));
    end
    clear_inputs();

    // Digital hold: 10 ticks right, release, one tick left.
    rst = 1'b1;
    repeat (2) run_cycle();
    rst = 1'b0;
    right[0] = 1'b1;
    repeat (10 * DIV_T) run_cycle();
    check_int("hold_right_sat", spin0_sat(), EXP_HOLD);
    check_int("hold_right_wrap", spin0_wrap(), EXP_HOLD);
    right[0] = 1'b0;
    repeat (DIV_T) run_cycle();
    left[0] = 1'b1;
    repeat (DIV_T) run_cycle();
    check_int("hold_left_sat", spin0_sat(), EXP_HOLD - 1);
    check_int("hold_left_wrap", spin0_wrap(), EXP_HOLD - 1);

    // Reset in the middle of a held run, then a fresh single tick.
    repeat (5 * DIV_T) run_cycle();
    rst = 1'b1;
    run_cycle();
    check_vec("midhold_reset_sat", {bus_sat.spin, bus_sat.moved, bus_sat.dir}, '0);
    check_vec("midhold_reset_wrap", {bus_wrap.spin, bus_wrap.moved, bus_wrap.dir}, '0);
    rst = 1'b0;
    left[0]  = 1'b0;
    right[0] = 1'b1;
    repeat (DIV_T) run_cycle();
    check_int("after_reset_tick", spin0_sat(), 1);

    // Strobe merged with a tick step: one +6 update, one pulse.
    repeat (DIV_T - 1) run_cycle();
    check_int("merge_pre_moved", int'(bus_sat.moved[0]), 0);
    strobe[0]     = 1'b1;
    delta[DW-1:0] = DW'(5);
    run_cycle();
    check_int("merge_spin", spin0_sat(), 7);
    check_int("merge_moved", int'(bus_sat.moved[0]), 1);
    strobe[0] = 1'b0;
    run_cycle();
    check_int("merge_post_moved", int'(bus_sat.moved[0]), 0);
    check_int("merge_post_spin", spin0_sat(), 7);
    clear_inputs();

    // Randomized traffic on all channels against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        strobe[c] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 1)
          delta[c*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
        else
          delta[c*DW +: DW] = DW'(int'($urandom_range(0, 15)) - 8);
        if ($urandom_range(0, 47) == 0) begin
          left[c]  = 1'($urandom_range(0, 1));
          right[c] = 1'($urandom_range(0, 1));
        end
        center[c] = ($urandom_range(0, 63) == 0);
      end
      rst = ($urandom_range(0, 999) == 0);
      run_cycle();
    end

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arcade_spinner.md
# arcade_spinner

Multi-channel rotary-control accumulator for arcade cores: converts per-channel signed relative deltas (mouse/trackball packets) and digital left/right holds (keyboard or joystick) into absolute dial positions for the game's input ports. It sits between the input-mapping logic and the core's INPx muxing. It generalises the single 9-bit saturating mouse spinner to N channels, configurable width, saturate-or-wrap arithmetic, and digital-input emulation with optional acceleration.

## Interface
- CHANNELS, 2: number of independent dials
- WIDTH, 9: accumulator width, signed two's complement
- DELTA_W, 9: width of each signed delta input
- SATURATE, 1: 1 = clamp at signed limits; 0 = modulo 2^WIDTH wrap
- DIV, 40000: clk_sys cycles per digital step tick (≥2)
- STEP_MIN, 1: initial and non-accelerated digital step magnitude
- STEP_MAX, 8: maximum accelerated step magnitude
- ACCEL_TICKS, 8: ticks held before the step increments by 1
- clk_sys  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- delta_strobe  in  CHANNELS  one-cycle valid per channel
- delta  in  CHANNELS*DELTA_W  packed signed deltas; channel i at [i*DELTA_W +: DELTA_W]
- dig_left  in  CHANNELS  digital decrement hold
- dig_right  in  CHANNELS  digital increment hold
- center  in  CHANNELS  synchronous load of position to 0
- spin  out  CHANNELS*WIDTH  packed signed positions, registered
- moved  out  CHANNELS  one-cycle pulse when spin value changed
- dir  out  CHANNELS  last nonzero movement direction, 1 = negative

## Operation
- Per channel, with priority reset > center > update.
- Update term = (delta_strobe ? sext(delta) : 0) + (tick & exactly one of left/right held ? ±step : 0); a single signed add at WIDTH+2 bits, so a simultaneous strobe and tick are merged into one update.
- SATURATE=1: clamp the sum to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. SATURATE=0: truncate to WIDTH bits.
- moved = 1 only if the new value ≠ old value. Pushing into a saturated limit produces no pulse.
- dir is updated only when the update term is nonzero; it holds its value otherwise, including on center.
- Tick counter is shared across channels, counts 0..DIV-1, and tick asserts for the one cycle when the counter equals DIV-1.
- Both or neither of left/right held: no digital step, and the step register returns to STEP_MIN.
- A delta with |delta| ≥ 2^WIDTH is clamped or wrapped by the same rule. No overflow is possible in the WIDTH+2-bit intermediate for DELTA_W ≤ WIDTH+1, and that constraint is enforced by an elaboration check.

## Timing
- Latency 1: the inputs sampled at edge n appear on spin/moved/dir after edge n.
- Inputs are level-sampled every cycle. No handshake; delta_strobe must not be asserted for more than one cycle per packet.
- Reset values: spin 0, moved 0, dir 0, tick counter 0, step STEP_MIN, hold counters 0.
- center takes effect on the next edge. It overrides a same-cycle strobe/tick, and moved pulses if the old value was ≠ 0.
- Reset asserted mid-hold or mid-accel clears all state on the next edge. The tick phase restarts from 0.

## Configuration
- SPINNER_ACCEL_EN defined: each channel keeps a hold counter and direction. Each tick held in the same direction increments the counter. On reaching ACCEL_TICKS, the counter clears and step = min(step+1, STEP_MAX). A reversal, release, or both-held condition resets step to STEP_MIN and the counter to 0.
- Not defined: step is the constant STEP_MIN, and no hold counters are synthesised.

## Structure
- spinner_pkg holds the sat_add clamp function and the packed-slice index helpers.
- The sub-module spinner_channel is instantiated per channel via generate and owns the accumulator, step, and hold counter. The tick counter lives in the top module.

## Test plan
- SATURATE=1, WIDTH=9: spin=250, strobe delta=+10 → spin=255, moved=1. A further +1 → spin=255, moved=0.
- SATURATE=0: spin=250, delta=+10 → spin=-252. From -256, delta=-1 → 255, dir=1 then 0.
- DIV=4, accel on, STEP_MIN=1, ACCEL_TICKS=8: hold right for 10 ticks → step of 1 ×8, then 2 ×2, spin=12. Release, then hold left 1 tick → spin=11.
- Strobe delta=+5 on the same cycle as a tick with right held (step 1) → spin +6, exactly one moved pulse.
- center asserted together with strobe delta=+3 at spin=40 → spin=0, moved=1, dir unchanged.
- Assert reset mid-hold at spin=-7, step=3 → all outputs 0 next cycle. Hold right 1 tick after reset → spin=1.
